// File: rtl/bcd_n_line_decoder_if.sv
// Handshake and decoded-line bundle for bcd_n_line_decoder.
// err_cnt exists only when DEC_ERR_CNT_EN is defined.
interface bcd_n_line_decoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] Y_n;
  logic [8:0] I_n;
  logic [3:0] digit;
  logic       out_valid;
  logic       err;
  logic       err_sticky;
  logic       err_clr;
`ifdef DEC_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  modport master (
    output in_valid, Y_n, err_clr,
    input  in_ready, I_n, digit, out_valid, err, err_sticky
`ifdef DEC_ERR_CNT_EN
    , input err_cnt
`endif
  );

  modport slave (
    input  in_valid, Y_n, err_clr,
    output in_ready, I_n, digit, out_valid, err, err_sticky
`ifdef DEC_ERR_CNT_EN
    , output err_cnt
`endif
  );
endinterface

// File: rtl/bcd_n_line_decoder.sv
// Registered inverted-BCD to 9-line active-low decoder with programmable dwell.
// Optional saturating illegal-code counter enabled by DEC_ERR_CNT_EN.
module bcd_n_line_decoder #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter bit          RETURN_IDLE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_n_line_decoder_if.slave  bus
);
  localparam int unsigned CW = 8;
  localparam int unsigned LW = 9;
  localparam int unsigned DW = 4;
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] i_n_q, i_n_d;
  logic [DW-1:0] digit_q, digit_d;
  logic          out_valid_q, out_valid_d;
  logic          err_q, err_d;
  logic          sticky_q, sticky_d;
  logic          ready_q, ready_d;
  logic          load;
  logic          accept;
  logic [DW-1:0] dec_digit;
  logic          dec_legal;
  logic [LW-1:0] dec_lines;

  assign accept = bus.in_valid & ready_q;

  // Code-to-lines decode; digit 0 and illegal codes leave every line high
  always_comb begin
    dec_digit = ~bus.Y_n;
    dec_legal = (dec_digit <= DW'(9));
    dec_lines = '1;
    if (dec_legal && (dec_digit != DW'(0)))
      dec_lines = ~(LW'(1) << (dec_digit - DW'(1)));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    i_n_d       = i_n_q;
    digit_d     = digit_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) load = 1'b1;
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (accept) begin
          load = 1'b1;
        end else begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          err_d       = 1'b0;
          if (RETURN_IDLE) begin
            i_n_d   = '1;
            digit_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d     = HOLD;
      cnt_d       = RELOAD;
      i_n_d       = dec_lines;
      digit_d     = dec_digit;
      out_valid_d = 1'b1;
      err_d       = ~dec_legal;
    end
    // Ready is registered, so it is derived from the next state/count
    ready_d = (state_d == IDLE) || (cnt_d == '0);
  end

  // Set wins over a coincident clear
  always_comb begin
    sticky_d = sticky_q;
    if (bus.err_clr) sticky_d = 1'b0;
    if (accept && !dec_legal) sticky_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      i_n_q       <= '1;
      digit_q     <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      sticky_q    <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      i_n_q       <= i_n_d;
      digit_q     <= digit_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      sticky_q    <= sticky_d;
      ready_q     <= ready_d;
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.I_n        = i_n_q;
  assign bus.digit      = digit_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.err        = err_q;
  assign bus.err_sticky = sticky_q;

`ifdef DEC_ERR_CNT_EN
  localparam int unsigned EW = 8;
  logic [EW-1:0] errcnt_q, errcnt_d;

  // Clear first, then a saturating increment, so clear+increment yields 1
  always_comb begin
    errcnt_d = errcnt_q;
    if (bus.err_clr) errcnt_d = '0;
    if (accept && !dec_legal && (errcnt_d != '1)) errcnt_d = errcnt_d + EW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) errcnt_q <= '0;
    else     errcnt_q <= errcnt_d;
  end

  assign bus.err_cnt = errcnt_q;
`endif
endmodule

// File: tb/tb_bcd_n_line_decoder.sv
// Self-checking bench: three decoder configurations driven in lockstep,
// each compared every cycle against a transaction-level reference model.
module tb_bcd_n_line_decoder;
  localparam int NM = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_n_line_decoder_if ia();
  bcd_n_line_decoder_if ib();
  bcd_n_line_decoder_if ic();

  bcd_n_line_decoder #(.HOLD_CYCLES(4), .RETURN_IDLE(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  bcd_n_line_decoder #(.HOLD_CYCLES(1), .RETURN_IDLE(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  bcd_n_line_decoder #(.HOLD_CYCLES(4), .RETURN_IDLE(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(ic));

  int errors = 0;
  int checks = 0;

  int hold_of [NM] = '{4, 1, 4};
  bit ret_of  [NM] = '{1'b1, 1'b1, 1'b0};
  logic [8:0] pat [10] = '{9'h1FF, 9'h1FE, 9'h1FD, 9'h1FB, 9'h1F7,
                           9'h1EF, 9'h1DF, 9'h1BF, 9'h17F, 9'h0FF};

  // Reference model: what each decoder is showing and for how many cycles
  bit         showing  [NM];
  int         age      [NM];
  int         code     [NM];
  bit         m_ready  [NM];
  bit         m_sticky [NM];
  int         m_cnt    [NM];
  logic [8:0] m_in     [NM];
  int         m_dig    [NM];
  bit         m_err    [NM];
  bit         m_ov     [NM];
  bit         accepted [NM];

  task automatic chk(string tag, int k, logic [8:0] obs, logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NM; k++) begin
      showing[k] = 1'b0; age[k] = 0; code[k] = 0; m_ready[k] = 1'b1;
      m_sticky[k] = 1'b0; m_cnt[k] = 0; m_in[k] = 9'h1FF; m_dig[k] = 0;
      m_err[k] = 1'b0; m_ov[k] = 1'b0; accepted[k] = 1'b0;
    end
  endtask

  task automatic model_edge(bit v, logic [3:0] y, bit clr);
    logic [3:0] nd;
    int d;
    bit acc;
    nd = ~y;
    d  = int'(nd);
    for (int k = 0; k < NM; k++) begin
      acc = v && m_ready[k];
      accepted[k] = acc;
      if (acc) begin
        showing[k] = 1'b1; age[k] = 1; code[k] = d;
      end else if (showing[k]) begin
        if (age[k] == hold_of[k]) showing[k] = 1'b0;
        else age[k]++;
      end
      m_ready[k] = !showing[k] || (age[k] == hold_of[k]);
      if (showing[k]) begin
        m_in[k]  = (code[k] < 10) ? pat[code[k]] : 9'h1FF;
        m_dig[k] = code[k];
        m_ov[k]  = 1'b1;
        m_err[k] = (code[k] > 9);
      end else begin
        m_ov[k]  = 1'b0;
        m_err[k] = 1'b0;
        if (ret_of[k]) begin
          m_in[k] = 9'h1FF; m_dig[k] = 0;
        end
      end
      if (clr) begin
        m_sticky[k] = 1'b0; m_cnt[k] = 0;
      end
      if (acc && d > 9) begin
        m_sticky[k] = 1'b1;
        if (m_cnt[k] < 255) m_cnt[k]++;
      end
    end
  endtask

  task automatic check_all();
    logic [8:0] o_in;
    logic [3:0] o_dig;
    logic o_ov, o_err, o_st, o_rdy;
    logic [7:0] o_cnt;
    for (int k = 0; k < NM; k++) begin
      o_cnt = '0;
      case (k)
        0: begin
          o_in = ia.I_n; o_dig = ia.digit; o_ov = ia.out_valid; o_err = ia.err;
          o_st = ia.err_sticky; o_rdy = ia.in_ready;
`ifdef DEC_ERR_CNT_EN
          o_cnt = ia.err_cnt;
`endif
        end
        1: begin
          o_in = ib.I_n; o_dig = ib.digit; o_ov = ib.out_valid; o_err = ib.err;
          o_st = ib.err_sticky; o_rdy = ib.in_ready;
`ifdef DEC_ERR_CNT_EN
          o_cnt = ib.err_cnt;
`endif
        end
        default: begin
          o_in = ic.I_n; o_dig = ic.digit; o_ov = ic.out_valid; o_err = ic.err;
          o_st = ic.err_sticky; o_rdy = ic.in_ready;
`ifdef DEC_ERR_CNT_EN
          o_cnt = ic.err_cnt;
`endif
        end
      endcase
      chk("I_n",        k, o_in,        m_in[k]);
      chk("digit",      k, 9'(o_dig),   9'(m_dig[k]));
      chk("out_valid",  k, 9'(o_ov),    9'(m_ov[k]));
      chk("err",        k, 9'(o_err),   9'(m_err[k]));
      chk("err_sticky", k, 9'(o_st),    9'(m_sticky[k]));
      chk("in_ready",   k, 9'(o_rdy),   9'(m_ready[k]));
`ifdef DEC_ERR_CNT_EN
      chk("err_cnt",    k, 9'(o_cnt),   9'(m_cnt[k]));
`endif
    end
  endtask

  task automatic drive(bit v, logic [3:0] y, bit clr);
    ia.in_valid = v; ib.in_valid = v; ic.in_valid = v;
    ia.Y_n = y;      ib.Y_n = y;      ic.Y_n = y;
    ia.err_clr = clr; ib.err_clr = clr; ic.err_clr = clr;
  endtask

  task automatic step(bit v, logic [3:0] y, bit clr);
    drive(v, y, clr);
    @(posedge clk);
    model_edge(v, y, clr);
    #1;
    check_all();
  endtask

  // Holds a code until the HOLD_CYCLES=4 instances accept it
  task automatic send(logic [3:0] y);
    int n;
    n = 0;
    do begin
      step(1'b1, y, 1'b0);
      n++;
    end while (!accepted[0] && n < 20);
  endtask

  initial begin
    drive(1'b0, 4'hF, 1'b0);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Sweep all legal digits back-to-back
    for (int d = 0; d < 10; d++) send(~4'(d));
    repeat (6) step(1'b0, 4'hF, 1'b0);

    // Illegal code, then a legal one, then clear
    send(4'b0011);
    send(4'b1110);
    step(1'b0, 4'hF, 1'b1);
    repeat (5) step(1'b0, 4'hF, 1'b0);

    // Single code expiring
    send(4'b1100);
    repeat (6) step(1'b0, 4'hF, 1'b0);

    // Random traffic with valid held high
    repeat (60) step(1'b1, 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
    repeat (30) step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0);
    repeat (6) step(1'b0, 4'hF, 1'b0);

    // Counter saturation, then clear coincident with an illegal accept
    repeat (1250) step(1'b1, 4'b0000, 1'b0);
    begin
      int n;
      n = 0;
      while (!m_ready[0] && n < 10) begin
        step(1'b0, 4'hF, 1'b0);
        n++;
      end
    end
    step(1'b1, 4'b0101, 1'b1);
    repeat (6) step(1'b0, 4'hF, 1'b0);

    // Asynchronous reset in the middle of a hold showing digit 9
    send(4'b0110);
    step(1'b0, 4'hF, 1'b0);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 4'hF, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
